bus_master_if: RTL

- CPU-side bus master port that sits between the core's memory-access stage and bus master slot 0.
- Converts a level request from the pipeline (read or write, word address, write data) into the bus protocol: req/grnt arbitration, one-cycle address strobe, then wait for slave ready.
- Returns read data and a done/error pulse to the pipeline.
- Includes a ready-timeout watchdog so an unmapped or hung slave cannot stall the core forever.

---
 rtl/bus_master_if.sv | 121 ++++++++++++
 1 files changed

// File: rtl/bus_master_if.sv
// Bus master port for slot 0.
// Turns a level-held pipeline memory request into a bus transaction.
// The transaction is req/grant arbitration, then a one-cycle address strobe,
// then a wait for slave ready. A watchdog bounds the wait, so a dead slave
// ends the access with an error completion instead of stalling the core.
module bus_master_if #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 30,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rest,
  input  logic              mem_req_i,
  input  logic              mem_rw_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [DATA_W-1:0] mem_wr_data_i,
  input  logic              flush_i,
  output logic [DATA_W-1:0] mem_rd_data_o,
  output logic              mem_done_o,
  output logic              mem_err_o,
  output logic              mem_busy_o,
  output logic              bus_req_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic              bus_as_o,
  output logic              bus_rw_o,
  output logic [DATA_W-1:0] bus_wr_data_o,
  input  logic              bus_grnt_i,
  input  logic              bus_rdy_i,
  input  logic [DATA_W-1:0] bus_rd_data_i
);

  typedef enum logic [1:0] {IDLE, REQ, ACCESS, WAIT} state_t;

  // Watchdog terminal count: the cycle in which a still-missing ready becomes an error.
  localparam logic [7:0] LAST_COUNT = 8'(TIMEOUT - 1);

  state_t      r_state;
  logic [7:0]  r_count;
  logic        r_discard;

  logic        w_discard;
  logic        w_timeout;

  // A flush that arrives in the same cycle as the completion still suppresses the done pulse.
  assign w_discard = r_discard | flush_i;
  assign w_timeout = (r_count == LAST_COUNT) && !bus_rdy_i;

  // Protocol sequencer: all bus-side and pipeline-side outputs are registered here.
  always_ff @(posedge clk) begin
    if (rest) begin
      r_state       <= IDLE;
      r_count       <= '0;
      r_discard     <= 1'b0;
      mem_rd_data_o <= '0;
      mem_done_o    <= 1'b0;
      mem_err_o     <= 1'b0;
      mem_busy_o    <= 1'b0;
      bus_req_o     <= 1'b0;
      bus_addr_o    <= '0;
      bus_as_o      <= 1'b0;
      bus_rw_o      <= 1'b0;
      bus_wr_data_o <= '0;
    end else begin
      mem_done_o    <= 1'b0;
      mem_err_o     <= 1'b0;
      mem_rd_data_o <= '0;
      case (r_state)
        IDLE: begin
          r_discard <= 1'b0;
          // The request is still high during the done cycle, so it must not start a second access.
          if (mem_req_i && !mem_done_o && !flush_i) begin
            bus_addr_o    <= mem_addr_i;
            bus_rw_o      <= mem_rw_i;
            bus_wr_data_o <= mem_wr_data_i;
            bus_req_o     <= 1'b1;
            mem_busy_o    <= 1'b1;
            r_state       <= REQ;
          end
        end
        REQ: begin
          if (bus_grnt_i) begin
            bus_as_o <= 1'b1;
            r_count  <= '0;
            r_state  <= ACCESS;
            if (flush_i) begin
              r_discard <= 1'b1;
            end
          end else if (flush_i) begin
            bus_req_o  <= 1'b0;
            mem_busy_o <= 1'b0;
            r_state    <= IDLE;
          end
        end
        ACCESS, WAIT: begin
          bus_as_o <= 1'b0;
          r_count  <= r_count + 8'd1;
          if (flush_i) begin
            r_discard <= 1'b1;
          end
          if (bus_rdy_i || w_timeout) begin
            bus_req_o  <= 1'b0;
            mem_busy_o <= 1'b0;
            r_discard  <= 1'b0;
            r_state    <= IDLE;
            if (!w_discard) begin
              mem_done_o <= 1'b1;
              mem_err_o  <= !bus_rdy_i;
              if (bus_rdy_i && bus_rw_o) begin
                mem_rd_data_o <= bus_rd_data_i;
              end
            end
          end else begin
            r_state <= WAIT;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
